// File: rtl/pipeline_add3.sv
// Two-stage pipelined three-operand adder, full-precision unsigned sum.
// Define PIPELINE_ADD3_INREG_EN to add an input register stage (3-edge latency).
module pipeline_add3 #(
   parameter int WIDTH     = 10,
   parameter int OUT_WIDTH = 12
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [WIDTH-1:0]     in1,
   input  logic [WIDTH-1:0]     in2,
   input  logic [WIDTH-1:0]     in3,
   output logic [OUT_WIDTH-1:0] out
);

   if (OUT_WIDTH < WIDTH + 2) begin : g_width_chk
      $error("pipeline_add3: OUT_WIDTH must be >= WIDTH+2");
   end

   typedef struct packed {
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic [WIDTH-1:0] c;
   } ops_t;

   typedef struct packed {
      logic [WIDTH:0]   ab;
      logic [WIDTH-1:0] c;
   } s1_t;

   ops_t ops;
   s1_t  s1_q;

`ifdef PIPELINE_ADD3_INREG_EN
   ops_t in_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         in_q <= '0;
      end else begin
         in_q <= '{a: in1, b: in2, c: in3};
      end
   end

   assign ops = in_q;
`else
   assign ops = '{a: in1, b: in2, c: in3};
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q <= '0;
      end else begin
         s1_q.ab <= {1'b0, ops.a} + {1'b0, ops.b};
         s1_q.c  <= ops.c;
      end
   end

   // Both operands widened to the result width so no carry is lost
   always_ff @(posedge clk) begin
      if (rst) begin
         out <= '0;
      end else begin
         out <= OUT_WIDTH'(s1_q.ab) + OUT_WIDTH'(s1_q.c);
      end
   end

endmodule

// File: tb/tb_pipeline_add3.sv
// Scoreboard bench for pipeline_add3: directed vectors with hand sums.
// Latency model follows PIPELINE_ADD3_INREG_EN.
module tb_pipeline_add3;

`ifdef PIPELINE_ADD3_INREG_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 2;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [9:0]  in1, in2, in3;
   logic [11:0] out;

   pipeline_add3 #(.WIDTH(10), .OUT_WIDTH(12)) dut (
      .clk(clk),
      .rst(rst),
      .in1(in1),
      .in2(in2),
      .in3(in3),
      .out(out)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       r;
      logic [9:0] a;
      logic [9:0] b;
      logic [9:0] c;
      int         s;
   } vec_t;

   vec_t        vecs[$];
   logic [11:0] exp_q[$];
   logic [11:0] pipe[LAT-1];
   int          tests = 0;
   int          fails = 0;

   task automatic add(input logic r, input int a, input int b,
                      input int c, input int s, input int n);
      vec_t v;
      v.r = r;
      v.a = 10'(a);
      v.b = 10'(b);
      v.c = 10'(c);
      v.s = s;
      for (int k = 0; k < n; k++) vecs.push_back(v);
   endtask

   task automatic apply(input vec_t v);
      rst = v.r;
      in1 = v.a;
      in2 = v.b;
      in3 = v.c;
   endtask

   // Expected out after this edge, given the vector sampled on it
   task automatic model_edge(input vec_t v);
      logic [11:0] e;
      if (v.r) begin
         e = '0;
         for (int k = 0; k < LAT-1; k++) pipe[k] = '0;
      end else begin
         e = pipe[LAT-2];
         for (int k = LAT-2; k > 0; k--) pipe[k] = pipe[k-1];
         pipe[0] = 12'(v.s);
      end
      exp_q.push_back(e);
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         logic [11:0] e;
         e = exp_q.pop_front();
         tests++;
         if (out !== e) begin
            fails++;
            $display("FAIL out_check t=%0t: got %0d expected %0d",
                     $time, out, e);
         end
      end
   end

   initial begin
      for (int k = 0; k < LAT-1; k++) pipe[k] = '0;
      // reset sequence and release
      add(1, 0, 0, 0, 0, 2);
      add(0, 0, 0, 0, 0, 2);
      // steady operands
      add(0, 3, 8, 2, 13, 4);
      // back-to-back stream
      add(0, 5, 1, 5, 11, 1);
      add(0, 8, 5, 5, 18, 1);
      add(0, 8, 5, 2, 15, 1);
      // reset mid-stream
      add(0, 3, 8, 2, 13, 2);
      add(1, 5, 1, 5, 11, 2);
      add(0, 8, 5, 5, 18, 4);
      // boundaries
      add(0, 1023, 1023, 1023, 3069, 3);
      add(0, 0, 0, 0, 0, 3);
      add(0, 1023, 1, 0, 1024, 3);
      add(0, 1023, 1023, 1023, 3069, 1);
      add(0, 0, 0, 0, 0, 1);
      add(0, 1023, 1, 0, 1024, 1);
      // drain
      add(0, 0, 0, 0, 0, 3);

      apply(vecs[0]);
      for (int i = 0; i < vecs.size(); i++) begin
         @(posedge clk);
         model_edge(vecs[i]);
         #1;
         if (i + 1 < vecs.size()) apply(vecs[i+1]);
      end
      repeat (3) @(negedge clk);
      #1;
      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
